// File: rtl/stream_avg.sv
// Streaming signed averager: accepts a run-time count of samples over a
// valid/ready stream. It accumulates them at full precision, divides the sum
// by the count one quotient bit per cycle, and holds sum and average on a
// valid/ready output until the consumer takes them.
//
// state | meaning
// IDLE  | waiting for start; num captured here
// ACC   | in_ready high, summing samples until cnt reaches num
// DIV   | restoring divide of |acc| by num, ACCW bit steps + sign fix-up
// DONE  | out_valid high, results held until out_ready
module stream_avg #(
  parameter int DATAW = 16,
  parameter int MAXN  = 8,
  parameter int CNTW  = $clog2(MAXN + 1),
  parameter int ACCW  = DATAW + CNTW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNTW-1:0]  num,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_avg,
  output logic [ACCW-1:0]  out_sum,
  output logic             out_err,
  output logic             busy
);

  localparam int DCW = $clog2(ACCW + 1);

  typedef enum logic [1:0] {IDLE, ACC, DIV, DONE} state_t;

  state_t state, state_nx;

  logic [CNTW-1:0]  num_r;
  logic [CNTW-1:0]  cnt;
  logic [ACCW-1:0]  acc;
  logic [ACCW-1:0]  quo;
  logic [CNTW-1:0]  rem;
  logic [DCW-1:0]   dcnt;
  logic             neg;

  logic             legal;
  logic             accept;
  logic             last;
  logic             div_done;
  logic [ACCW-1:0]  acc_nx;
  logic [ACCW-1:0]  acc_abs_nx;
  logic [CNTW:0]    trial;
  logic             fits;
  logic [CNTW-1:0]  rem_nx;
  logic [DATAW-1:0] avg_signed;

  assign legal      = (num != '0) && (num <= CNTW'(MAXN));
  assign accept     = (state == ACC) && in_valid;
  assign last       = (cnt + CNTW'(1)) == num_r;
  assign div_done   = (dcnt == DCW'(ACCW));
  assign acc_nx     = acc + {{CNTW{in_data[DATAW-1]}}, in_data};
  assign acc_abs_nx = acc_nx[ACCW-1] ? (~acc_nx + ACCW'(1)) : acc_nx;

  // One restoring step: shift the next dividend bit into the remainder and
  // subtract num when it fits. The remainder stays below num, so CNTW bits suffice.
  assign trial      = {rem, quo[ACCW-1]};
  assign fits       = (trial >= {1'b0, num_r});
  assign rem_nx     = fits ? CNTW'(trial - {1'b0, num_r}) : trial[CNTW-1:0];

  // Low DATAW bits of the negated quotient equal the negation of its low bits.
  assign avg_signed = neg ? (~quo[DATAW-1:0] + DATAW'(1)) : quo[DATAW-1:0];

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start)             state_nx = legal ? ACC : DONE;
      ACC:  if (accept && last)    state_nx = DIV;
      DIV:  if (div_done)          state_nx = DONE;
      DONE: if (out_ready)         state_nx = IDLE;
      default:                     state_nx = IDLE;
    endcase
  end

  // Datapath: capture, accumulate, divide and hold results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_r   <= '0;
      cnt     <= '0;
      acc     <= '0;
      quo     <= '0;
      rem     <= '0;
      dcnt    <= '0;
      neg     <= 1'b0;
      out_avg <= '0;
      out_sum <= '0;
      out_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            num_r   <= num;
            cnt     <= '0;
            acc     <= '0;
            out_avg <= '0;
            out_sum <= '0;
            out_err <= ~legal;
          end
        end
        ACC: begin
          if (accept) begin
            acc <= acc_nx;
            cnt <= cnt + CNTW'(1);
            if (last) begin
              quo  <= acc_abs_nx;
              neg  <= acc_nx[ACCW-1];
              rem  <= '0;
              dcnt <= '0;
            end
          end
        end
        DIV: begin
          if (!div_done) begin
            rem  <= rem_nx;
            quo  <= {quo[ACCW-2:0], fits};
            dcnt <= dcnt + DCW'(1);
          end else begin
            out_avg <= avg_signed;
            out_sum <= acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_avg.sv
// Randomised and directed bench for stream_avg. The reference is the plain
// integer sum of the samples and integer division by the count, which
// truncates toward zero.
module tb_stream_avg;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  num;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_avg;
  logic [19:0] out_sum;
  logic        out_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int samp[$];

  stream_avg dut (
    .clk(clk), .rst(rst), .start(start), .num(num),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_avg(out_avg), .out_sum(out_sum), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one run and reports what was observed; the test tasks judge it.
  task automatic do_run(input int n, input int gap_max, input int stall, input bit start_on_release,
                        output int sum, output int avg, output int err, output int lat,
                        output int stable, output int idle_after, output int rdy_done,
                        output int timeout);
    int budget;
    int g;
    timeout = 0;
    stable = 1;
    start = 1'b1;
    num = 4'(n);
    @(posedge clk); #1;
    start = 1'b0;
    if (n >= 1 && n <= 8) begin
      for (int i = 0; i < n; i++) begin
        g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        in_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data = 16'(samp[i]);
        budget = 0;
        while (!in_ready && budget < 100) begin @(posedge clk); #1; budget++; end
        if (budget >= 100) timeout = 1;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
    end
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    if (!out_valid) timeout = 1;
    rdy_done = int'(in_ready);
    sum = $signed(out_sum);
    avg = $signed(out_avg);
    err = int'(out_err);
    out_ready = 1'b0;
    repeat (stall) begin
      @(posedge clk); #1;
      if (!out_valid || $signed(out_sum) != sum || $signed(out_avg) != avg || int'(out_err) != err)
        stable = 0;
    end
    out_ready = 1'b1;
    if (start_on_release) begin start = 1'b1; num = 4'd4; end
    @(posedge clk); #1;
    out_ready = 1'b0;
    start = 1'b0;
    idle_after = int'(!out_valid && !busy);
    @(posedge clk); #1;
    if (busy || in_ready) idle_after = 0;
  endtask

  function automatic int ref_sum();
    int s = 0;
    foreach (samp[i]) s += samp[i];
    return s;
  endfunction

  task automatic test_reset();
    checks++;
    if ({in_ready, out_valid, out_err, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {in_ready, out_valid, out_err, busy});
    end
    checks++;
    if (out_avg !== 16'd0 || out_sum !== 20'd0) begin
      errors++;
      $display("FAIL reset_data: got avg %0h sum %0h expected 0 0", out_avg, out_sum);
    end
  endtask

  task automatic test_basic();
    int s, a, e, l, st, ia, rd, to;
    samp = {1, 2, 3, 4, 5, 6, 7, 8};
    do_run(8, 0, 0, 0, s, a, e, l, st, ia, rd, to);
    checks++; if (to !== 0)  begin errors++; $display("FAIL basic_timeout: got %0d expected 0", to); end
    checks++; if (s !== 36)  begin errors++; $display("FAIL basic_sum: got %0d expected 36", s); end
    checks++; if (a !== 4)   begin errors++; $display("FAIL basic_avg: got %0d expected 4", a); end
    checks++; if (l !== 21)  begin errors++; $display("FAIL basic_latency: got %0d expected 21", l); end
    checks++; if (e !== 0)   begin errors++; $display("FAIL basic_err: got %0d expected 0", e); end
    checks++; if (ia !== 1)  begin errors++; $display("FAIL basic_idle_after: got %0d expected 1", ia); end
  endtask

  task automatic test_negative();
    int s, a, e, l, st, ia, rd, to;
    samp = {-3, -4};
    do_run(2, 0, 0, 0, s, a, e, l, st, ia, rd, to);
    checks++; if (s !== -7 || to !== 0) begin errors++; $display("FAIL neg_sum: got %0d (to %0d) expected -7", s, to); end
    checks++; if (a !== -3) begin errors++; $display("FAIL neg_avg: got %0d expected -3", a); end
    samp = {-32768};
    do_run(1, 0, 0, 0, s, a, e, l, st, ia, rd, to);
    checks++; if (a !== -32768 || to !== 0) begin errors++; $display("FAIL num1_avg: got %0d (to %0d) expected -32768", a, to); end
    checks++; if (s !== -32768) begin errors++; $display("FAIL num1_sum: got %0d expected -32768", s); end
  endtask

  task automatic test_max();
    int s, a, e, l, st, ia, rd, to;
    samp = {32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
    do_run(8, 0, 0, 0, s, a, e, l, st, ia, rd, to);
    checks++; if (s !== 262136 || to !== 0) begin errors++; $display("FAIL max_sum: got %0d (to %0d) expected 262136", s, to); end
    checks++; if (a !== 32767) begin errors++; $display("FAIL max_avg: got %0d expected 32767", a); end
  endtask

  task automatic test_illegal();
    int s, a, e, l, st, ia, rd, to;
    int bad[2] = '{0, 9};
    samp = {};
    for (int k = 0; k < 2; k++) begin
      do_run(bad[k], 0, 0, 0, s, a, e, l, st, ia, rd, to);
      checks++; if (l !== 0 || to !== 0) begin errors++; $display("FAIL illegal%0d_latency: got %0d (to %0d) expected 0", bad[k], l, to); end
      checks++; if (e !== 1) begin errors++; $display("FAIL illegal%0d_err: got %0d expected 1", bad[k], e); end
      checks++; if (a !== 0 || s !== 0) begin errors++; $display("FAIL illegal%0d_data: got avg %0d sum %0d expected 0 0", bad[k], a, s); end
      checks++; if (rd !== 0) begin errors++; $display("FAIL illegal%0d_ready: got %0d expected 0", bad[k], rd); end
    end
  endtask

  task automatic test_stall();
    int s, a, e, l, st, ia, rd, to, rs;
    samp = {};
    for (int i = 0; i < 5; i++) samp.push_back(int'($urandom_range(0, 65535)) - 32768);
    rs = ref_sum();
    do_run(5, 3, 10, 0, s, a, e, l, st, ia, rd, to);
    checks++; if (s !== rs || to !== 0) begin errors++; $display("FAIL stall_sum: got %0d (to %0d) expected %0d", s, to, rs); end
    checks++; if (a !== rs / 5) begin errors++; $display("FAIL stall_avg: got %0d expected %0d", a, rs / 5); end
    checks++; if (st !== 1) begin errors++; $display("FAIL stall_stable: got %0d expected 1", st); end
    checks++; if (l !== 21) begin errors++; $display("FAIL stall_latency: got %0d expected 21", l); end
  endtask

  task automatic test_start_in_done();
    int s, a, e, l, st, ia, rd, to;
    samp = {9};
    do_run(1, 0, 2, 1, s, a, e, l, st, ia, rd, to);
    checks++; if (a !== 9 || to !== 0) begin errors++; $display("FAIL sid_avg: got %0d (to %0d) expected 9", a, to); end
    checks++; if (ia !== 1) begin errors++; $display("FAIL sid_start_ignored: got idle %0d expected 1", ia); end
  endtask

  task automatic test_reset_mid();
    int s, a, e, l, st, ia, rd, to;
    int seen;
    start = 1'b1; num = 4'd8;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'd100;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, out_err, busy} !== 4'b0000 || out_avg !== 16'd0 || out_sum !== 20'd0) begin
      errors++;
      $display("FAIL midrst_outputs: got flags %b avg %0h sum %0h expected all 0",
               {in_ready, out_valid, out_err, busy}, out_avg, out_sum);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (30) begin @(posedge clk); #1; if (out_valid || busy) seen = 1; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_quiet: got activity %0d expected 0", seen); end
    samp = {4, 4, 4, 4};
    do_run(4, 0, 0, 0, s, a, e, l, st, ia, rd, to);
    checks++; if (a !== 4 || to !== 0) begin errors++; $display("FAIL midrst_rerun_avg: got %0d (to %0d) expected 4", a, to); end
    checks++; if (s !== 16) begin errors++; $display("FAIL midrst_rerun_sum: got %0d expected 16", s); end
  endtask

  task automatic test_random();
    int s, a, e, l, st, ia, rd, to, rs, n;
    for (int r = 0; r < 25; r++) begin
      n = int'($urandom_range(1, 8));
      samp = {};
      for (int i = 0; i < n; i++) samp.push_back(int'($urandom_range(0, 65535)) - 32768);
      rs = ref_sum();
      do_run(n, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 0, s, a, e, l, st, ia, rd, to);
      checks++;
      if (s !== rs || a !== rs / n || e !== 0 || to !== 0) begin
        errors++;
        $display("FAIL rand%0d n=%0d: got sum %0d avg %0d err %0d to %0d expected sum %0d avg %0d err 0",
                 r, n, s, a, e, to, rs, rs / n);
      end
      checks++;
      if (st !== 1 || l !== 21) begin
        errors++;
        $display("FAIL rand%0d_timing: got stable %0d latency %0d expected 1 21", r, st, l);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num = 4'd0; in_valid = 1'b0; in_data = 16'd0; out_ready = 1'b0;
    #3;
    test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    // A valid sample presented while idle must not be consumed.
    in_valid = 1'b1; in_data = 16'h7fff;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    test_basic();
    test_negative();
    test_max();
    test_illegal();
    test_stall();
    test_start_in_done();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
